// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants for the memory stage: aluop codes, FSM states and lane helpers.
package mem_access_ctrl_pkg;

    localparam logic        WriteEnable  = 1'b1;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;

    localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [7:0] EXE_ADD_OP = 8'b0010_0000;
    localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } mem_state_e;

    function automatic logic is_load(input logic [7:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    function automatic logic is_half(input logic [7:0] op);
        return (op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP);
    endfunction

    function automatic logic is_word(input logic [7:0] op);
        return (op == EXE_LW_OP) || (op == EXE_SW_OP);
    endfunction

    function automatic logic [31:0] store_lanes(input logic [7:0] op, input logic [31:0] d);
        case (op)
            EXE_SB_OP: return {4{d[7:0]}};
            EXE_SH_OP: return {2{d[15:0]}};
            default:   return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Big-endian lane select and load extraction (sign/zero extend) for one access.
module mem_load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [1:0]  addr_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ldata_o,
    output logic [3:0]  sel_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        ldata_o = '0;
        sel_o   = '0;
        byte_v  = '0;
        half_v  = '0;
        case (aluop_i)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: begin
                case (addr_i)
                    2'b00:   begin byte_v = rdata_i[31:24]; sel_o = 4'b1000; end
                    2'b01:   begin byte_v = rdata_i[23:16]; sel_o = 4'b0100; end
                    2'b10:   begin byte_v = rdata_i[15:8];  sel_o = 4'b0010; end
                    default: begin byte_v = rdata_i[7:0];   sel_o = 4'b0001; end
                endcase
                ldata_o = (aluop_i == EXE_LB_OP) ? {{24{byte_v[7]}}, byte_v} : {24'b0, byte_v};
            end
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: begin
                half_v  = addr_i[1] ? rdata_i[15:0] : rdata_i[31:16];
                sel_o   = addr_i[1] ? 4'b0011 : 4'b1100;
                ldata_o = (aluop_i == EXE_LH_OP) ? {{16{half_v[15]}}, half_v} : {16'b0, half_v};
            end
            EXE_LW_OP, EXE_SW_OP: begin
                sel_o   = 4'b1111;
                ldata_o = rdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage engine: ALU pass-through, bus req/ack for loads/stores with timeout.
// Optional MEM_ALIGN_EXC_EN: misaligned accesses raise excp_misalign_o instead of being forced aligned.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] store_data_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic        bus_err_o
`ifdef MEM_ALIGN_EXC_EN
    ,
    output logic        excp_misalign_o
`endif
);

    mem_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             bus_req_q, bus_we_q, err_q;
    logic [31:0]      bus_addr_q, bus_wdata_q, result_q;
    logic [3:0]       bus_sel_q;

    logic        ld, st, mem_op, access;
    logic [31:0] addr_eff, ldata;
    logic [3:0]  sel;

    assign ld     = is_load(aluop_i);
    assign st     = is_store(aluop_i);
    assign mem_op = ld | st;

`ifdef MEM_ALIGN_EXC_EN
    logic misalign;
    assign misalign = (is_half(aluop_i) & mem_addr_i[0]) | (is_word(aluop_i) & (|mem_addr_i[1:0]));
    assign addr_eff = mem_addr_i;
    assign access   = mem_op & ~misalign;
`else
    always_comb begin
        addr_eff = mem_addr_i;
        if (is_half(aluop_i)) addr_eff[0] = 1'b0;
        if (is_word(aluop_i)) addr_eff[1:0] = 2'b00;
    end
    assign access = mem_op;
`endif

    // result_q is zero after a timeout, so extraction naturally yields 0
    mem_load_align u_align (
        .addr_i  (addr_eff[1:0]),
        .aluop_i (aluop_i),
        .rdata_i (result_q),
        .ldata_o (ldata),
        .sel_o   (sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_sel_q   <= '0;
            bus_wdata_q <= '0;
            err_q       <= 1'b0;
            result_q    <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (access) begin
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= st;
                        bus_addr_q  <= {addr_eff[31:2], 2'b00};
                        bus_sel_q   <= sel;
                        bus_wdata_q <= store_lanes(aluop_i, store_data_i);
                        cnt_q       <= '0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus_ack_i) begin
                        result_q  <= bus_rdata_i;
                        bus_req_q <= 1'b0;
                        state_q   <= ST_DONE;
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        result_q  <= '0;
                        bus_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_sel_o   = bus_sel_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_err_o   = err_q;

    always_comb begin
        wd_o       = NOPRegAddr;
        wreg_o     = WriteDisable;
        wdata_o    = ZeroWord;
        stallreq_o = 1'b0;
`ifdef MEM_ALIGN_EXC_EN
        excp_misalign_o = 1'b0;
`endif
        if (!rst) begin
            wd_o       = wd_i;
            wreg_o     = wreg_i;
            wdata_o    = wdata_i;
            stallreq_o = (state_q == ST_WAIT) || ((state_q == ST_IDLE) && access);
            if (st) wreg_o = WriteDisable;
            if (ld) wdata_o = ldata;
`ifdef MEM_ALIGN_EXC_EN
            if ((state_q == ST_IDLE) && mem_op && misalign) begin
                excp_misalign_o = 1'b1;
                wreg_o          = WriteDisable;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed cases plus randomized loads/stores.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] store_data_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        bus_err_o;
`ifdef MEM_ALIGN_EXC_EN
    logic        excp_misalign_o;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    mem_access_ctrl #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .wd_i         (wd_i),
        .wreg_i       (wreg_i),
        .wdata_i      (wdata_i),
        .aluop_i      (aluop_i),
        .mem_addr_i   (mem_addr_i),
        .store_data_i (store_data_i),
        .wd_o         (wd_o),
        .wreg_o       (wreg_o),
        .wdata_o      (wdata_o),
        .stallreq_o   (stallreq_o),
        .bus_req_o    (bus_req_o),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_sel_o    (bus_sel_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_ack_i    (bus_ack_i),
        .bus_rdata_i  (bus_rdata_i),
        .bus_err_o    (bus_err_o)
`ifdef MEM_ALIGN_EXC_EN
        ,
        .excp_misalign_o (excp_misalign_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes and the byte offset inside the word
    function automatic int unsigned ref_size(input logic [7:0] op);
        if (op == EXE_LW_OP || op == EXE_SW_OP) return 4;
        if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] ref_addr(input logic [7:0] op, input logic [31:0] addr);
`ifdef MEM_ALIGN_EXC_EN
        return addr;
`else
        return addr & ~32'(ref_size(op) - 1);
`endif
    endfunction

    function automatic logic [3:0] ref_sel(input logic [7:0] op, input logic [31:0] addr);
        int unsigned size = ref_size(op);
        int unsigned off  = ref_addr(op, addr) % 4;
        int unsigned bits = ((1 << size) - 1) << (4 - size - off);
        return 4'(bits);
    endfunction

    function automatic logic [31:0] ref_load(input logic [7:0] op, input logic [31:0] addr,
                                             input logic [31:0] rd);
        int unsigned size  = ref_size(op);
        int unsigned off   = ref_addr(op, addr) % 4;
        int unsigned shift = 8 * (4 - size - off);
        logic [31:0] mask  = (size == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * size)) - 32'h1);
        logic [31:0] v     = (rd >> shift) & mask;
        if ((op == EXE_LB_OP || op == EXE_LH_OP) && v[8 * size - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [7:0] op, input logic [31:0] sd);
        int unsigned size = ref_size(op);
        if (size == 1) return {24'b0, sd[7:0]} * 32'h0101_0101;
        if (size == 2) return {16'b0, sd[15:0]} * 32'h0001_0001;
        return sd;
    endfunction

    function automatic bit ref_is_store(input logic [7:0] op);
        return op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP;
    endfunction

    // Runs one memory transaction starting from IDLE; returns in IDLE with a non-memory op driven.
    task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sd,
                           input logic [4:0] wd, input logic wreg, input logic [31:0] alu,
                           input logic [31:0] rd, input int unsigned delay, input bit noack);
        bit st = ref_is_store(op);
        aluop_i      = op;
        mem_addr_i   = addr;
        store_data_i = sd;
        wd_i         = wd;
        wreg_i       = wreg;
        wdata_i      = alu;
        #1;
        chk("idle_stall", 32'(stallreq_o), 32'd1);
        @(posedge clk); #1;
        chk("wait_req",   32'(bus_req_o),  32'd1);
        chk("wait_we",    32'(bus_we_o),   32'(st));
        chk("wait_addr",  bus_addr_o,      addr & 32'hFFFF_FFFC);
        chk("wait_sel",   32'(bus_sel_o),  32'(ref_sel(op, addr)));
        if (st) chk("wait_wdata", bus_wdata_o, ref_wdata(op, sd));
        if (noack) begin
            repeat (15) begin
                @(posedge clk); #1;
                chk("to_stall", 32'(stallreq_o), 32'd1);
                chk("to_noerr", 32'(bus_err_o),  32'd0);
            end
            @(posedge clk); #1;
        end else begin
            repeat (delay) begin
                @(posedge clk); #1;
                chk("wait_stall", 32'(stallreq_o), 32'd1);
            end
            bus_ack_i   = 1'b1;
            bus_rdata_i = rd;
            @(posedge clk); #1;
            bus_ack_i   = 1'b0;
            bus_rdata_i = $urandom;
        end
        chk("done_stall", 32'(stallreq_o), 32'd0);
        chk("done_req",   32'(bus_req_o),  32'd0);
        chk("done_err",   32'(bus_err_o),  32'(noack));
        chk("done_wd",    32'(wd_o),       32'(wd));
        chk("done_wreg",  32'(wreg_o),     st ? 32'd0 : 32'(wreg));
        chk("done_wdata", wdata_o,         st ? alu : (noack ? 32'd0 : ref_load(op, addr, rd)));
        aluop_i = EXE_ADD_OP;
        @(posedge clk); #1;
        chk("idle_err",   32'(bus_err_o),  32'd0);
        chk("idle_nostl", 32'(stallreq_o), 32'd0);
        chk("idle_noreq", 32'(bus_req_o),  32'd0);
    endtask

    logic [7:0] mem_ops [8];
    logic [7:0] alu_ops [3];

    initial begin
        mem_ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                    EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
        alu_ops = '{EXE_ADD_OP, EXE_OR_OP, EXE_NOP_OP};
        rst = 1'b1;
        wd_i = '0; wreg_i = 1'b0; wdata_i = '0; aluop_i = EXE_NOP_OP;
        mem_addr_i = '0; store_data_i = '0; bus_ack_i = 1'b0; bus_rdata_i = '0;

        // Reset state
        repeat (2) @(posedge clk);
        wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
        #1;
        chk("rst_wd",    32'(wd_o),       32'd0);
        chk("rst_wreg",  32'(wreg_o),     32'd0);
        chk("rst_wdata", wdata_o,         32'd0);
        chk("rst_stall", 32'(stallreq_o), 32'd0);
        chk("rst_req",   32'(bus_req_o),  32'd0);
        chk("rst_sel",   32'(bus_sel_o),  32'd0);
        chk("rst_addr",  bus_addr_o,      32'd0);
        chk("rst_err",   32'(bus_err_o),  32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ALU pass-through, same cycle
        aluop_i = EXE_ADD_OP; wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h1234;
        #1;
        chk("add_wd",    32'(wd_o),       32'd3);
        chk("add_wreg",  32'(wreg_o),     32'd1);
        chk("add_wdata", wdata_o,         32'h1234);
        chk("add_stall", 32'(stallreq_o), 32'd0);

        // Ack outside WAIT has no effect
        bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus_ack_i = 1'b0;
        chk("stray_req",   32'(bus_req_o),  32'd0);
        chk("stray_stall", 32'(stallreq_o), 32'd0);
        chk("stray_wdata", wdata_o,         32'h1234);

        // Directed memory cases
        run_mem(EXE_LB_OP,  32'h101, 32'h0,  5'd4, 1'b1, 32'h0, 32'h11F2_3344, 0, 1'b0);
        run_mem(EXE_LHU_OP, 32'h002, 32'h0,  5'd5, 1'b1, 32'h0, 32'hAAAA_8001, 0, 1'b0);
        run_mem(EXE_SB_OP,  32'h003, 32'h5A, 5'd6, 1'b1, 32'h77, 32'h0,       1, 1'b0);
        run_mem(EXE_LW_OP,  32'h040, 32'h0,  5'd8, 1'b1, 32'h0, 32'h0,        0, 1'b1);
        run_mem(EXE_LH_OP,  32'h000, 32'h0,  5'd9, 1'b1, 32'h0, 32'h8001_7FFF, 3, 1'b0);

        // Reset in the middle of WAIT abandons the access
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h80; wd_i = 5'd2; wreg_i = 1'b1;
        @(posedge clk); #1;
        chk("mid_req", 32'(bus_req_o), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_req",   32'(bus_req_o),  32'd0);
        chk("mid_rst_stall", 32'(stallreq_o), 32'd0);
        chk("mid_rst_wreg",  32'(wreg_o),     32'd0);
        chk("mid_rst_wdata", wdata_o,         32'd0);
        chk("mid_rst_addr",  bus_addr_o,      32'd0);
        aluop_i = EXE_ADD_OP; wdata_i = 32'h00C0_FFEE; rst = 1'b0;
        bus_ack_i = 1'b1; bus_rdata_i = 32'h1357_9BDF;
        @(posedge clk); #1;
        bus_ack_i = 1'b0;
        chk("late_ack_stall", 32'(stallreq_o), 32'd0);
        chk("late_ack_req",   32'(bus_req_o),  32'd0);
        chk("late_ack_err",   32'(bus_err_o),  32'd0);
        chk("late_ack_wdata", wdata_o,         32'h00C0_FFEE);

`ifdef MEM_ALIGN_EXC_EN
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h6; wreg_i = 1'b1;
        #1;
        chk("mis_excp",  32'(excp_misalign_o), 32'd1);
        chk("mis_stall", 32'(stallreq_o),      32'd0);
        chk("mis_wreg",  32'(wreg_o),          32'd0);
        @(posedge clk); #1;
        chk("mis_noreq", 32'(bus_req_o),       32'd0);
        aluop_i = EXE_ADD_OP;
        @(posedge clk); #1;
`endif

        // Randomized pass-through
        for (int i = 0; i < 8; i++) begin
            logic [7:0] op;
            op = alu_ops[$urandom_range(0, 2)];
            aluop_i = op; wd_i = 5'($urandom); wreg_i = 1'($urandom); wdata_i = $urandom;
            mem_addr_i = $urandom;
            #1;
            chk("rnd_pt_wd",    32'(wd_o),       32'(wd_i));
            chk("rnd_pt_wreg",  32'(wreg_o),     32'(wreg_i));
            chk("rnd_pt_wdata", wdata_o,         wdata_i);
            chk("rnd_pt_stall", 32'(stallreq_o), 32'd0);
            @(posedge clk); #1;
        end

        // Randomized memory transactions
        for (int i = 0; i < 30; i++) begin
            logic [7:0]  op;
            logic [31:0] addr;
            op   = mem_ops[$urandom_range(0, 7)];
            addr = $urandom;
`ifdef MEM_ALIGN_EXC_EN
            addr = addr & ~32'(ref_size(op) - 1);
`endif
            run_mem(op, addr, $urandom, 5'($urandom), 1'($urandom), $urandom, $urandom,
                    $urandom_range(0, 5), ($urandom_range(0, 9) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Memory-stage engine that consumes the EX/MEM pipeline register outputs.
- For ALU results it passes them straight through to the MEM/WB register.
- For loads and stores it runs a request/acknowledge transaction on the data bus, holds the pipeline with stallreq until the transaction completes, then presents the aligned, extended load result.
- Sits between ex_mem and mem_wb; the data-RAM or bus slave is the responder.

Parameters:
- TIMEOUT_CYCLES, 16: maximum WAIT cycles before the access is aborted.
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wd_i  in  5  destination register address from EX/MEM
- wreg_i  in  1  register write enable from EX/MEM
- wdata_i  in  32  ALU result from EX/MEM
- aluop_i  in  8  operation code; memory ops are LB, LBU, LH, LHU, LW, SB, SH, SW
- mem_addr_i  in  32  effective address
- store_data_i  in  32  store source register value
- wd_o  out  5  to MEM/WB
- wreg_o  out  1  to MEM/WB
- wdata_o  out  32  to MEM/WB
- stallreq_o  out  1  stall request to the pipeline controller
- bus_req_o  out  1  bus request, registered
- bus_we_o  out  1  1 = write, registered
- bus_addr_o  out  32  word address, low 2 bits zero, registered
- bus_sel_o  out  4  byte-lane enables, registered
- bus_wdata_o  out  32  store data replicated across lanes, registered
- bus_ack_i  in  1  responder completion strobe, one cycle
- bus_rdata_i  in  32  read data, valid with bus_ack_i
- bus_err_o  out  1  one-cycle pulse on timeout abort
- excp_misalign_o  out  1  misaligned-access flag; present only with the optional feature

Behaviour:
- Reset (rst=1 at clk edge):
  - State IDLE; timeout counter 0.
  - All bus_* outputs 0; bus_err_o 0; result register 0.
  - While rst=1, wd_o, wreg_o, wdata_o and stallreq_o are forced to 0.
  - Reset mid-transaction abandons the access immediately; no ack is expected afterwards.
- Non-memory aluop_i: pass-through in the same cycle, stallreq_o 0, state stays IDLE.
- Byte lanes are big-endian:
  - addr[1:0]=00 selects bits [31:24], sel 1000; 11 selects bits [7:0], sel 0001.
  - Halfword: addr[1]=0 gives sel 1100, addr[1]=1 gives sel 0011.
  - Word: sel 1111.
- Store data: byte replicated x4; halfword replicated x2.
- FSM, states IDLE, WAIT, DONE:
  - IDLE with a memory op:
    - stallreq_o=1, combinational.
    - Next edge: latch addr, sel, we and wdata into the bus registers; bus_req_o←1; go to WAIT.
  - WAIT:
    - stallreq_o=1; counter increments each cycle.
    - bus_ack_i=1 at an edge: capture bus_rdata_i into the result register, bus_req_o←0, go to DONE.
    - Counter reaching TIMEOUT_CYCLES-1 without ack: bus_req_o←0, one-cycle bus_err_o pulse, go to DONE. The load result is 0, and wreg_o is still driven from wreg_i.
  - DONE:
    - stallreq_o=0; wdata_o shows the extracted load result (stores: wdata_o = wdata_i).
    - Next edge: go to IDLE. The pipeline advances on that same edge, so the instruction is not re-issued.
- Latency: a load acked in the first WAIT cycle costs 2 stall cycles; DONE is the release cycle.
- Load extraction: LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
- Stores set wreg_o=0 regardless of wreg_i.
- bus_ack_i outside WAIT is ignored.

Optional Feature:
- Macro: MEM_ALIGN_EXC_EN.
- Defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠00, start no bus access.
  - excp_misalign_o=1 in the same cycle, stallreq_o=0, wreg_o=0.
  - The port exists.
- Undefined:
  - The port is absent.
  - Offending low address bits are forced to 0 (halfword: bit 0; word: bits 1:0) and the access proceeds normally.

Decomposition:
- defines.v holds the aluop codes, enable/disable constants, zero_word, NOPRegAddr and the FSM state encodings.
- One combinational sub-module, mem_load_align: inputs addr[1:0], aluop and 32-bit raw data; outputs the extended load value and the lane select.

Test Plan:
- ADD result: wd_i=3, wreg_i=1, wdata_i=0x1234 → wd_o=3, wreg_o=1, wdata_o=0x1234 the same cycle; stallreq_o stays 0.
- LB at addr 0x101, responder acks in the first WAIT cycle with rdata 0x11F2_3344:
  - Expect bus_sel_o=0100 and bus_addr_o=0x100.
  - stallreq_o high for 2 cycles.
  - DONE shows wdata_o=0xFFFF_FFF2.
- LHU at addr 0x2, ack with 0xAAAA_8001 → bus_sel_o=0011, wdata_o=0x0000_8001.
- SB data 0x5A at addr 0x3:
  - bus_we_o=1, bus_sel_o=0001, bus_wdata_o=0x5A5A_5A5A.
  - wreg_o=0 in DONE.
- LW with no ack and TIMEOUT_CYCLES=16:
  - bus_err_o pulses after 16 WAIT cycles.
  - wdata_o=0.
  - stallreq_o drops in DONE.
- rst asserted during WAIT:
  - Next cycle all outputs are 0 and the state is IDLE.
  - A late bus_ack_i is ignored.
  - With MEM_ALIGN_EXC_EN, LW at 0x6 gives excp_misalign_o=1 and no bus_req_o.
